// File: rtl/fp_flopoco_pkg.sv
// Shared FloPoCo single-precision encoding: exception tags, 34-bit word layout
// and a saturating 16-bit counter helper.
package fp_flopoco_pkg;

  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_e;

  typedef struct packed {
    exn_e        exn;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } flopoco_word_t;

  localparam int FLOPOCO_W = $bits(flopoco_word_t);

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fp_sp_ieee_classify.sv
// Combinational IEEE-754 binary32 -> FloPoCo conversion with class flags.
// Define FP_SUBNORMAL_MAP_EN to map large subnormals instead of flushing them.
module fp_sp_ieee_classify
  import fp_flopoco_pkg::*;
(
  input  logic [31:0]   ieee_i,
  output flopoco_word_t word_o,
  output logic          is_nan_o,
  output logic          is_subn_o
);

  logic        sign_f;
  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic        exp_zero;
  logic        exp_max;
  logic        frac_zero;

  assign sign_f    = ieee_i[31];
  assign exp_f     = ieee_i[30:23];
  assign frac_f    = ieee_i[22:0];
  assign exp_zero  = (exp_f == 8'h00);
  assign exp_max   = (exp_f == 8'hFF);
  assign frac_zero = (frac_f == 23'h0);

  assign is_nan_o  = exp_max & ~frac_zero;
  assign is_subn_o = exp_zero & ~frac_zero;

  // Every class keeps the sign; only normals (and mapped subnormals) carry payload.
  always_comb begin
    word_o.exn  = EXN_ZERO;
    word_o.sign = sign_f;
    word_o.exp  = 8'h00;
    word_o.frac = 23'h0;
    if (exp_max) begin
      word_o.exn = frac_zero ? EXN_INF : EXN_NAN;
    end else if (!exp_zero) begin
      word_o.exn  = EXN_NORMAL;
      word_o.exp  = exp_f;
      word_o.frac = frac_f;
    end
`ifdef FP_SUBNORMAL_MAP_EN
    else if (frac_f[22]) begin
      word_o.exn  = EXN_NORMAL;
      word_o.frac = {frac_f[21:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/fp_sp_ieee_to_flopoco_stream.sv
// Elastic valid/ready stream converting IEEE-754 binary32 words to FloPoCo format,
// LATENCY (1 or 2) register stages. Subnormal mapping via FP_SUBNORMAL_MAP_EN.
module fp_sp_ieee_to_flopoco_stream
  import fp_flopoco_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [33:0] out_data,
  output logic [15:0] nan_count,
  output logic [15:0] subn_count
);

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("fp_sp_ieee_to_flopoco_stream: LATENCY must be 1 or 2");
  end

  flopoco_word_t cls_word;
  logic          cls_nan;
  logic          cls_subn;

  fp_sp_ieee_classify u_classify (
    .ieee_i    (in_data),
    .word_o    (cls_word),
    .is_nan_o  (cls_nan),
    .is_subn_o (cls_subn)
  );

  genvar gi;
  for (gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic          valid_q;
    logic          valid_d;
    flopoco_word_t data_q;
    flopoco_word_t data_d;
    logic          up_valid;
    flopoco_word_t up_data;
    logic          down_adv;
    logic          adv;

    if (gi == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = cls_word;
    end else begin : g_body
      assign up_valid = g_stage[gi-1].valid_q;
      assign up_data  = g_stage[gi-1].data_q;
    end

    if (gi == LATENCY - 1) begin : g_tail
      assign down_adv = out_ready;
    end else begin : g_mid
      assign down_adv = g_stage[gi+1].adv;
    end

    // A stage moves when it is empty or its content leaves downstream; ce freezes all.
    assign adv = ce & (~valid_q | down_adv);

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (adv) begin
        valid_d = up_valid;
        if (up_valid) begin
          data_d = up_data;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = g_stage[LATENCY-1].valid_q;
  assign out_data  = g_stage[LATENCY-1].data_q;

  logic        accept;
  logic [15:0] nan_q;
  logic [15:0] nan_d;
  logic [15:0] subn_q;
  logic [15:0] subn_d;

  assign accept = in_valid & in_ready;

  always_comb begin
    nan_d  = nan_q;
    subn_d = subn_q;
    if (accept && cls_nan) begin
      nan_d = sat_inc16(nan_q);
    end
    if (accept && cls_subn) begin
      subn_d = sat_inc16(subn_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_q  <= 16'h0;
      subn_q <= 16'h0;
    end else begin
      nan_q  <= nan_d;
      subn_q <= subn_d;
    end
  end

  assign nan_count  = nan_q;
  assign subn_count = subn_q;

endmodule

// File: tb/tb_fp_sp_ieee_to_flopoco_stream.sv
// Scoreboard bench: driver pushes reference-model results on acceptance, monitor
// pops and compares on every output presentation.
module tb_fp_sp_ieee_to_flopoco_stream;

  parameter int LATENCY = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
  logic [15:0] nan_count;
  logic [15:0] subn_count;

  always #5 clk = ~clk;

  fp_sp_ieee_to_flopoco_stream #(.LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .nan_count  (nan_count),
    .subn_count (subn_count)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          stall_cnt = 0;
  logic [33:0] exp_q[$];
  int          model_nan  = 0;
  int          model_subn = 0;
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference conversion straight from the format rules, using integer fields.
  function automatic logic [33:0] ref_conv(input logic [31:0] x);
    int   e;
    int   f;
    int   oe;
    int   of;
    int   exn;
    logic s;
    s   = x[31];
    e   = int'(x[30:23]);
    f   = int'(x[22:0]);
    oe  = 0;
    of  = 0;
    exn = 0;
    if (e == 255) begin
      exn = (f == 0) ? 2 : 3;
    end else if (e > 0) begin
      exn = 1;
      oe  = e;
      of  = f;
    end else begin
`ifdef FP_SUBNORMAL_MAP_EN
      if (f >= (1 << 22)) begin
        exn = 1;
        of  = (f * 2) % (1 << 23);
      end
`endif
    end
    return {exn[1:0], s, oe[7:0], of[22:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 6);
    case (k)
      0: w[30:23] = 8'h00;
      1: begin w[30:23] = 8'h00; w[22:0] = 23'h0; end
      2: w[30:23] = 8'hFF;
      3: begin w[30:23] = 8'hFF; w[22:0] = 23'h0; end
      default: ;
    endcase
    return w;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_nan  = 0;
      model_subn = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_with_empty_queue", out_valid, 1'b0);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (ce && out_ready) void'(exp_q.pop_front());
        end
      end
      if (ce && in_valid && in_ready) begin
        exp_q.push_back(ref_conv(in_data));
        if (in_data[30:23] == 8'hFF && in_data[22:0] != 0 && model_nan < 65535) model_nan++;
        if (in_data[30:23] == 8'h00 && in_data[22:0] != 0 && model_subn < 65535) model_subn++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the word until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [31:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      stall_cnt++;
      t++;
      if (t > 500) begin
        chk("send_timeout", in_ready, 1'b1);
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
  endtask

  task automatic send_expect(input string name, input logic [31:0] d, input logic [33:0] expv);
    int c;
    send(d);
    in_valid = 1'b0;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (out_valid || c > 20) break;
    end
    chk({name, "_latency"}, c, LATENCY);
    chk(name, out_data, expv);
    tick();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      tick();
      t++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 34'h0);
    chk("rst_nan_count", nan_count, 16'h0);
    chk("rst_subn_count", subn_count, 16'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1'b1);
    tick();

    // Directed classes
    send_expect("normal_one", 32'h3F800000, 34'h13F800000);
    send_expect("neg_inf", 32'hFF800000, 34'h280000000);
    send_expect("qnan", 32'h7FC00000, 34'h300000000);
    chk("nan_count_1", nan_count, 16'd1);
    send_expect("neg_zero", 32'h80000000, 34'h080000000);
`ifdef FP_SUBNORMAL_MAP_EN
    send_expect("subn_hi", 32'h00400000, 34'h100000000);
`else
    send_expect("subn_hi", 32'h00400000, 34'h000000000);
`endif
    send_expect("subn_lo", 32'h00200000, 34'h000000000);
    chk("subn_count_2", subn_count, 16'd2);

    // Random stream with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) send(rand_word());
    in_valid = 1'b0;
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    drain();
    chk("rand_nan_count", nan_count, model_nan);
    chk("rand_subn_count", subn_count, model_subn);

    // ce low for 5 cycles mid-stream
    rand_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send(rand_word());
        in_valid = 1'b0;
      end
      begin
        repeat (4) tick();
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("ce_low_in_ready", in_ready, 1'b0);
          chk("ce_low_nan_count", nan_count, model_nan);
          chk("ce_low_subn_count", subn_count, model_subn);
          tick();
        end
        ce = 1'b1;
      end
    join
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    drain();

    // Reset with words in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h7FC00001;
    tick();
    in_data   = 32'h00000001;
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_nan_count", nan_count, 16'h0);
    chk("midrst_subn_count", subn_count, 16'h0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    tick();

    // Saturation and bubble-free throughput
    stall_cnt = 0;
    for (int i = 0; i < 65540; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[30:23] = 8'hFF;
      if (w[22:0] == 23'h0) w[0] = 1'b1;
      send(w);
    end
    in_valid = 1'b0;
    drain();
    chk("no_bubbles", stall_cnt, 0);
    chk("nan_saturated", nan_count, 16'hFFFF);
    chk("nan_model", nan_count, model_nan);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
